// File: rtl/rf_bypass.sv
// Eight-entry register file with one write port and two combinational read ports.
// Define RF_BYPASS_EN to forward same-cycle write data to a matching read port.
module rf_bypass #(
  parameter  int DATA_W = 16,
  parameter  int NREGS  = 8,
  localparam int SEL_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  read1regsel,
  input  logic [SEL_W-1:0]  read2regsel,
  input  logic [SEL_W-1:0]  writeregsel,
  input  logic [DATA_W-1:0] writedata,
  input  logic              write,
  output logic [DATA_W-1:0] read1data,
  output logic [DATA_W-1:0] read2data,
  output logic              err
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  wr_en;

  // One-hot write decode; reset suppresses every enable so reset always wins.
  always_comb begin
    wr_en = '0;
    if (write && !rst) wr_en[writeregsel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (rst)           regs[i] <= '0;
      else if (wr_en[i]) regs[i] <= writedata;
    end
  end

  always_comb begin
    read1data = '0;
    read2data = '0;
    if (!rst) begin
      read1data = regs[read1regsel];
      read2data = regs[read2regsel];
`ifdef RF_BYPASS_EN
      // Write-before-read: the writeback result is visible to decode this cycle.
      if (write && (writeregsel == read1regsel)) read1data = writedata;
      if (write && (writeregsel == read2regsel)) read2data = writedata;
`endif
    end
  end

  // Sticky flag for unknown control/select inputs; a constant-0 flop in synthesis.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
`ifndef SYNTHESIS
      if ($isunknown({write, writeregsel, read1regsel, read2regsel})) err <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_rf_bypass.sv
// Bench for rf_bypass: directed test-plan cases plus randomized traffic checked
// against an array-based reference model.
module tb_rf_bypass;

  logic        clk;
  logic        rst;
  logic [2:0]  read1regsel;
  logic [2:0]  read2regsel;
  logic [2:0]  writeregsel;
  logic [15:0] writedata;
  logic        write;
  logic [15:0] read1data;
  logic [15:0] read2data;
  logic        err;

  rf_bypass dut (
    .clk         (clk),
    .rst         (rst),
    .read1regsel (read1regsel),
    .read2regsel (read2regsel),
    .writeregsel (writeregsel),
    .writedata   (writedata),
    .write       (write),
    .read1data   (read1data),
    .read2data   (read2data),
    .err         (err)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mdl [8];
  logic        mdl_live = 1'b0;
  logic [15:0] exp_q [$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [2:0] sel);
    if (rst) return 16'h0000;
`ifdef RF_BYPASS_EN
    if (write && writeregsel == sel) return writedata;
`endif
    return mdl[sel];
  endfunction

  // driver tasks
  task automatic apply(input logic r, input logic w, input logic [2:0] ws,
                       input logic [15:0] wd, input logic [2:0] r1, input logic [2:0] r2);
    rst = r; write = w; writeregsel = ws; writedata = wd;
    read1regsel = r1; read2regsel = r2;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    exp_q.push_back(model_read(read1regsel));
    exp_q.push_back(model_read(read2regsel));
    check({tag, "_rd1"}, read1data, exp_q.pop_front());
    check({tag, "_rd2"}, read2data, exp_q.pop_front());
    if (mdl_live) check({tag, "_err"}, {15'b0, err}, 16'h0000);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
      mdl_live = 1'b1;
    end else if (write) begin
      mdl[writeregsel] = writedata;
    end
    #1;
  endtask

  logic [15:0] exp_a, exp_b;

  initial begin
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;

    // Reset held two cycles with a write pending: write must be discarded.
    apply(1'b1, 1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3);
    for (int c = 0; c < 2; c++) begin
      settle();
      check("rst_rd1", read1data, 16'h0000);
      check("rst_rd2", read2data, 16'h0000);
      tick();
    end
    apply(1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd3);
    settle(); check("post_rst_r3", read1data, 16'h0000);
    check("post_rst_err", {15'b0, err}, 16'h0000);
    tick();

    // Write then read.
    apply(1'b0, 1'b1, 3'd5, 16'h1234, 3'd0, 3'd1);
    settle(); check_model("wr5"); tick();
    apply(1'b0, 1'b0, 3'd5, 16'hDEAD, 3'd5, 3'd0);
    settle();
    check("wr_rd_r5", read1data, 16'h1234);
    check("wr_rd_r0", read2data, 16'h0000);
    tick();

    // Dual bypass.
    apply(1'b0, 1'b1, 3'd2, 16'h00FF, 3'd4, 3'd4);
    settle(); check_model("wr2"); tick();
    apply(1'b0, 1'b1, 3'd2, 16'hA5A5, 3'd2, 3'd2);
    settle();
`ifdef RF_BYPASS_EN
    exp_a = 16'hA5A5;
`else
    exp_a = 16'h00FF;
`endif
    check("dual_byp_rd1", read1data, exp_a);
    check("dual_byp_rd2", read2data, exp_a);
    tick();
    apply(1'b0, 1'b0, 3'd2, 16'h0000, 3'd2, 3'd2);
    settle();
    check("dual_next_rd1", read1data, 16'hA5A5);
    check("dual_next_rd2", read2data, 16'hA5A5);
    tick();

    // Partial bypass.
    apply(1'b0, 1'b1, 3'd6, 16'h0606, 3'd1, 3'd1);
    settle(); check_model("wr6"); tick();
    apply(1'b0, 1'b1, 3'd7, 16'h8001, 3'd7, 3'd6);
    settle();
`ifdef RF_BYPASS_EN
    exp_a = 16'h8001;
`else
    exp_a = 16'h0000;
`endif
    check("part_byp_rd1", read1data, exp_a);
    check("part_byp_rd2", read2data, 16'h0606);
    tick();

    // Back-to-back writes to one register: last write wins.
    apply(1'b0, 1'b1, 3'd1, 16'hAAAA, 3'd1, 3'd0);
    settle(); check_model("b2b_a"); tick();
    apply(1'b0, 1'b1, 3'd1, 16'h5555, 3'd1, 3'd1);
    settle(); check_model("b2b_b"); tick();
    apply(1'b0, 1'b0, 3'd1, 16'hFFFF, 3'd1, 3'd1);
    settle(); check("b2b_final", read1data, 16'h5555); tick();

    // Full sweep, then idle cycles with random junk on the write bus.
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b1, 3'(i), 16'(32'h1111 * i), 3'($urandom_range(0, 7)), 3'(i));
      settle(); check_model("sweep_wr"); tick();
    end
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b0, 3'($urandom_range(0, 7)), 16'($urandom), 3'(i), 3'(7 - i));
      exp_a = 16'(32'h1111 * i);
      exp_b = 16'(32'h1111 * (7 - i));
      settle();
      check("sweep_rd1", read1data, exp_a);
      check("sweep_rd2", read2data, exp_b);
      tick();
    end

    // Reset mid-operation coincident with a write.
    apply(1'b1, 1'b1, 3'd4, 16'hFFFF, 3'd4, 3'd4);
    settle();
    check("mid_rst_rd1", read1data, 16'h0000);
    check("mid_rst_rd2", read2data, 16'h0000);
    tick();
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b0, 3'd4, 16'hFFFF, 3'(i), 3'(7 - i));
      settle();
      check("clr_rd1", read1data, 16'h0000);
      check("clr_rd2", read2data, 16'h0000);
      check("clr_err", {15'b0, err}, 16'h0000);
      tick();
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      apply(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1),
            3'($urandom_range(0, 7)), 16'($urandom),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      settle(); check_model("rand"); tick();
    end

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
